bus_arbiter: RTL

//  N-master, one-shared-bus arbiter for the LR35902 memory fabric (CPU, OAM DMA, HDMA, ...).

---
 rtl/bus_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: hands one shared slave bus to one of N masters per M-cycle, deciding on the ct==3 edge.
// Define ARB_STARVE_EN to add per-master wait counters and the starve output.
module bus_arbiter #(
   parameter int            N_MASTERS = 3,
   parameter int            AW        = 16,
   parameter int            DW        = 8,
   parameter int            PRIO_MODE = 0,
   parameter logic [DW-1:0] IDLE_DATA = 8'hFF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              ct,
   input  logic [N_MASTERS-1:0]    m_req,
   input  logic [N_MASTERS-1:0]    m_lock,
   input  logic [N_MASTERS-1:0]    m_wr,
   input  logic [N_MASTERS-1:0]    m_rd,
   input  logic [N_MASTERS*AW-1:0] m_a,
   input  logic [N_MASTERS*DW-1:0] m_dout,
   output logic [N_MASTERS*DW-1:0] m_din,
   output logic [N_MASTERS-1:0]    m_rvalid,
   output logic [N_MASTERS-1:0]    gnt,
   output logic [AW-1:0]           bus_a,
   output logic [DW-1:0]           bus_dout,
   input  logic [DW-1:0]           bus_din,
   output logic                    bus_rd,
`ifdef ARB_STARVE_EN
   output logic [N_MASTERS-1:0]    starve,
`endif
   output logic                    bus_wr
);

   localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   typedef enum logic {IDLE, OWNED} state_t;

   state_t                 state_q, state_d;
   logic [N_MASTERS-1:0]   gnt_q, gnt_d;
   logic [N_MASTERS-1:0]   rvalid_q, rvalid_d;
   logic [N_MASTERS-1:0]   win;
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [DW-1:0]          din_q [N_MASTERS];
   logic [DW-1:0]          din_d [N_MASTERS];
   logic                   decide;

`ifdef ARB_STARVE_EN
   logic [3:0]             cnt_q [N_MASTERS];
   logic [3:0]             cnt_d [N_MASTERS];
   logic [N_MASTERS-1:0]   starve_flag;
   logic [N_MASTERS-1:0]   starved;
`endif

   assign decide = (ct == 2'b11);

   function automatic logic [N_MASTERS-1:0] lowest_set(input logic [N_MASTERS-1:0] v);
      return v & (~v + N_MASTERS'(1));
   endfunction

   // Rotate so the master after the last owner sits at bit 0, pick lowest, rotate back.
   function automatic logic [N_MASTERS-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                     input logic [PW-1:0]        last);
      logic [2*N_MASTERS-1:0] wide;
      logic [N_MASTERS-1:0]   rot;
      logic [PW-1:0]          sh;
      sh   = last + PW'(1);
      wide = {req, req} >> sh;
      rot  = lowest_set(wide[N_MASTERS-1:0]);
      wide = {rot, rot} << sh;
      return wide[2*N_MASTERS-1:N_MASTERS];
   endfunction

`ifdef ARB_STARVE_EN
   always_comb begin
      for (int i = 0; i < N_MASTERS; i++) begin
         starve_flag[i] = (cnt_q[i] == 4'hF);
      end
      starved = starve_flag & m_req;
   end

   always_comb begin
      for (int i = 0; i < N_MASTERS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (!m_req[i]) begin
            cnt_d[i] = '0;
         end else if (decide) begin
            if (gnt_d[i]) begin
               cnt_d[i] = '0;
            end else if (!starve_flag[i]) begin
               cnt_d[i] = cnt_q[i] + 4'd1;
            end
         end
      end
   end

   assign starve = starve_flag;
`endif

   always_comb begin
      win     = '0;
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      if (decide) begin
         if (state_q == OWNED && |(gnt_q & m_lock & m_req)) begin
            win = gnt_q;
         end else if (PRIO_MODE == 1) begin
            win = rr_pick(m_req, ptr_q);
         end else begin
            win = lowest_set(m_req);
         end
`ifdef ARB_STARVE_EN
         if (|starved) begin
            win = lowest_set(starved);
         end
`endif
         gnt_d   = win;
         state_d = (|win) ? OWNED : IDLE;
         for (int i = 0; i < N_MASTERS; i++) begin
            if (win[i]) begin
               ptr_d = PW'(i);
            end
         end
      end
   end

   // Read data is captured for the owner that held the bus during the ending M-cycle.
   always_comb begin
      rvalid_d = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         din_d[i] = din_q[i];
      end
      if (decide) begin
         rvalid_d = gnt_q & m_rd;
         for (int i = 0; i < N_MASTERS; i++) begin
            if (!gnt_q[i]) begin
               din_d[i] = IDLE_DATA;
            end else if (m_rd[i]) begin
               din_d[i] = bus_din;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         rvalid_q <= '0;
         ptr_q    <= PW'(N_MASTERS - 1);
         for (int i = 0; i < N_MASTERS; i++) begin
            din_q[i] <= IDLE_DATA;
`ifdef ARB_STARVE_EN
            cnt_q[i] <= '0;
`endif
         end
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         ptr_q    <= ptr_d;
         din_q    <= din_d;
`ifdef ARB_STARVE_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   // gnt is one-hot or zero, so OR-ing the masked slices is a clean mux.
   always_comb begin
      bus_a    = '0;
      bus_dout = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (gnt_q[i]) begin
            bus_a    = bus_a | m_a[i*AW +: AW];
            bus_dout = bus_dout | m_dout[i*DW +: DW];
         end
      end
      bus_rd = |(gnt_q & m_rd);
      bus_wr = |(gnt_q & m_wr);
   end

   always_comb begin
      for (int i = 0; i < N_MASTERS; i++) begin
         m_din[i*DW +: DW] = din_q[i];
      end
   end

   assign gnt      = gnt_q;
   assign m_rvalid = rvalid_q;

endmodule
